// File: rtl/ldm_stm_sequencer.sv
// Load/store-multiple beat sequencer. It walks a register list one register per step,
// supplies the index and word address for each beat, and reports the final base value.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32,
  parameter int NREG   = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NREG-1:0]   reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              is_load,
  input  logic              up,
  input  logic              step,
  output logic              busy,
  output logic              mem_force,
  output logic [IDX_W-1:0]  reg_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

  state_t            state, state_next;
  logic [NREG-1:0]   rem, rem_next, rem_cleared;
  logic [ADDR_W-1:0] addr, addr_next, wb_addr_next;
  logic              load_flag, load_flag_next;
  logic              up_flag, up_flag_next;
  logic              wb_en_next;
  logic [IDX_W-1:0]  lo_idx, hi_idx;
  logic              multi;

  // Ascending scan keeps the last hit (highest); the mirrored scan keeps the lowest.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rem[i])          hi_idx = IDX_W'(i);
      if (rem[NREG-1-i])   lo_idx = IDX_W'(NREG - 1 - i);
    end
  end

  assign reg_idx     = up_flag ? lo_idx : hi_idx;
  assign rem_cleared = rem & ~(NREG'(1) << reg_idx);
  // More than one bit set exactly when clearing the lowest bit leaves something behind.
  assign multi       = |(rem & (rem - NREG'(1)));

  assign busy      = (state == XFER);
  assign mem_force = busy & multi;
  assign mem_re    = busy & load_flag;
  assign mem_we    = busy & ~load_flag;
  assign mem_addr  = addr;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next     = state;
    rem_next       = rem;
    addr_next      = addr;
    load_flag_next = load_flag;
    up_flag_next   = up_flag;
    wb_en_next     = 1'b0;
    wb_addr_next   = wb_addr;
    case (state)
      IDLE: begin
        if (start) begin
          if (reg_list != '0) begin
            rem_next       = reg_list;
            addr_next      = up ? base_addr : base_addr - WORD;
            load_flag_next = is_load;
            up_flag_next   = up;
            state_next     = XFER;
          end else begin
            wb_en_next   = 1'b1;
            wb_addr_next = base_addr;
          end
        end
      end
      XFER: begin
        if (step) begin
          rem_next  = rem_cleared;
          addr_next = up_flag ? addr + WORD : addr - WORD;
          if (rem_cleared == '0) begin
            state_next   = IDLE;
            wb_en_next   = 1'b1;
            // Descending: the final beat's own address is already base - 4n.
            wb_addr_next = up_flag ? addr + WORD : addr;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      addr      <= '0;
      load_flag <= 1'b0;
      up_flag   <= 1'b0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
    end else begin
      state     <= state_next;
      rem       <= rem_next;
      addr      <= addr_next;
      load_flag <= load_flag_next;
      up_flag   <= up_flag_next;
      wb_en     <= wb_en_next;
      wb_addr   <= wb_addr_next;
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: directed cases plus random sequences,
// compared against a list-walking reference model.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        is_load;
  logic        up;
  logic        step;
  logic        busy, mem_force, mem_re, mem_we, wb_en;
  logic [3:0]  reg_idx;
  logic [31:0] mem_addr, wb_addr;

  int checks   = 0;
  int failures = 0;

  ldm_stm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .reg_list(reg_list),
    .base_addr(base_addr), .is_load(is_load), .up(up), .step(step),
    .busy(busy), .mem_force(mem_force), .reg_idx(reg_idx), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_we(mem_we), .wb_en(wb_en), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"},      64'(busy),      64'd0);
    check({tag, ".mem_force"}, 64'(mem_force), 64'd0);
    check({tag, ".mem_re"},    64'(mem_re),    64'd0);
    check({tag, ".mem_we"},    64'(mem_we),    64'd0);
    check({tag, ".wb_en"},     64'(wb_en),     64'd0);
  endtask

  // Reference model: the beats are the set bits of the list in transfer order, each one
  // word further from the base; descending transfers start one word below the base.
  // both: raise step together with start. poke: fire a conflicting start mid-sequence.
  task automatic run_seq(input string name, input logic [15:0] lst, input logic [31:0] base,
                         input logic u, input logic ld, input bit both, input bit poke,
                         input int max_gap);
    int          idx_q[$];
    logic [31:0] addr_q[$];
    int          n;
    logic [31:0] exp_wb;
    for (int i = 0; i < 16; i++) begin
      int r;
      r = u ? i : 15 - i;
      if (lst[r]) idx_q.push_back(r);
    end
    n = idx_q.size();
    for (int k = 0; k < n; k++)
      addr_q.push_back(u ? base + 32'(4 * k) : base - 32'(4 * (k + 1)));
    exp_wb = u ? base + 32'(4 * n) : base - 32'(4 * n);

    @(negedge clk);
    start = 1'b1; reg_list = lst; base_addr = base; up = u; is_load = ld; step = both;
    @(negedge clk);
    start = 1'b0; step = 1'b0;
    reg_list = $urandom(); base_addr = $urandom(); up = $urandom(); is_load = $urandom();

    if (n == 0) begin
      check({name, ".empty.busy"},      64'(busy),      64'd0);
      check({name, ".empty.mem_force"}, 64'(mem_force), 64'd0);
      check({name, ".empty.wb_en"},     64'(wb_en),     64'd1);
      check({name, ".empty.wb_addr"},   64'(wb_addr),   64'(base));
    end else begin
      for (int k = 0; k < n; k++) begin
        int gap;
        gap = $urandom_range(max_gap, 0);
        for (int g = 0; g <= gap; g++) begin
          string t;
          t = $sformatf("%s.beat%0d", name, k);
          check({t, ".busy"},      64'(busy),      64'd1);
          check({t, ".reg_idx"},   64'(reg_idx),   64'(idx_q[k]));
          check({t, ".mem_addr"},  64'(mem_addr),  64'(addr_q[k]));
          check({t, ".mem_force"}, 64'(mem_force), 64'(k < n - 1));
          check({t, ".mem_re"},    64'(mem_re),    64'(ld));
          check({t, ".mem_we"},    64'(mem_we),    64'(!ld));
          check({t, ".wb_en"},     64'(wb_en),     64'd0);
          if (g < gap) begin
            start = poke; reg_list = ~lst; base_addr = ~base; up = ~u; is_load = ~ld;
            @(negedge clk);
            start = 1'b0;
          end
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
      end
      check({name, ".done.busy"},    64'(busy),    64'd0);
      check({name, ".done.wb_en"},   64'(wb_en),   64'd1);
      check({name, ".done.wb_addr"}, 64'(wb_addr), 64'(exp_wb));
    end
    @(negedge clk);
    check({name, ".after.wb_en"}, 64'(wb_en), 64'd0);
    check({name, ".after.busy"},  64'(busy),  64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; step = 1'b0;
    reg_list = '0; base_addr = '0; is_load = 1'b0; up = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("reset.reg_idx",  64'(reg_idx),  64'd0);
    check("reset.mem_addr", 64'(mem_addr), 64'd0);
    check("reset.wb_addr",  64'(wb_addr),  64'd0);
    reset = 1'b0;

    // Step while idle does nothing.
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check_quiet("idle_step");

    run_seq("asc_load",   16'h0015, 32'h0000_1000, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    run_seq("desc_store", 16'h8001, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_seq("empty",      16'h0000, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run_seq("wrap",       16'h0003, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    run_seq("wrap_down",  16'h0101, 32'h0000_0004, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    run_seq("poke",       16'h0A50, 32'h0000_3000, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    run_seq("start_step", 16'h00C2, 32'h0000_5000, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    run_seq("full_down",  16'hFFFF, 32'h0000_8000, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Reset after one of four steps aborts without a writeback.
    @(negedge clk);
    start = 1'b1; reg_list = 16'h000F; base_addr = 32'h0000_6000; up = 1'b1; is_load = 1'b1;
    @(negedge clk);
    start = 1'b0; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("rst_mid.pre.reg_idx", 64'(reg_idx), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_quiet("rst_mid.async");
    check("rst_mid.async.reg_idx",  64'(reg_idx),  64'd0);
    check("rst_mid.async.mem_addr", 64'(mem_addr), 64'd0);
    step = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_quiet($sformatf("rst_mid.hold%0d", c));
    end
    step = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid.released");
    run_seq("after_rst", 16'h0009, 32'h0000_7000, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    for (int r = 0; r < 25; r++) begin
      logic [15:0] lst;
      lst = (r % 6 == 5) ? 16'h0000 : 16'($urandom());
      run_seq($sformatf("rand%0d", r), lst, 32'($urandom()) & 32'hFFFF_FFFC,
              1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
